// File: rtl/poci_bus_n.sv
// poci_bus_n: single-master, NSLV-slave POCI (APB-style) interconnect.
// Decodes the paddr page against a per-slave base table and latches the
// selected slave at SETUP. It then holds that selection through ACCESS and
// watches for stuck slaves with a watchdog. Unmapped, timed-out and malformed
// transfers are completed by the bus itself with pslverr=1, and error status
// is published for a system fault register.
//
// Ports
//   pclk, preset               clock, synchronous active-high reset
//   m_psel .. m_pwdata         master request inputs
//   m_prdata/m_pready/m_pslverr  response returned to the master
//   s_psel                     one-hot slave select
//   s_penable .. s_pwdata      request broadcast to all slaves (unregistered)
//   s_prdata/s_pready/s_pslverr  per-slave responses (slave i at lane i)
//   err_valid                  one-cycle pulse after a bus-generated error
//   err_code                   last error: 01 unmapped, 10 timeout, 11 protocol
//   err_addr                   m_paddr of the last bus-generated error
//   err_cnt                    saturating count of bus-generated errors
module poci_bus_n #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEC_LSB = 12,
  parameter logic [NSLV*(32-DEC_LSB)-1:0] BASE = {20'h00004, 20'h00003, 20'h00002, 20'h00001},
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               m_psel,
  input  logic               m_penable,
  input  logic               m_pwrite,
  input  logic [31:0]        m_paddr,
  input  logic [DW-1:0]      m_pwdata,
  output logic [DW-1:0]      m_prdata,
  output logic               m_pready,
  output logic               m_pslverr,
  output logic [NSLV-1:0]    s_psel,
  output logic               s_penable,
  output logic               s_pwrite,
  output logic [31:0]        s_paddr,
  output logic [DW-1:0]      s_pwdata,
  input  logic [NSLV*DW-1:0] s_prdata,
  input  logic [NSLV-1:0]    s_pready,
  input  logic [NSLV-1:0]    s_pslverr,
  output logic               err_valid,
  output logic [1:0]         err_code,
  output logic [31:0]        err_addr,
  output logic [15:0]        err_cnt
);

  localparam int unsigned PW  = 32 - DEC_LSB;
  localparam int unsigned IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ErrUnmapped = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  localparam logic [1:0] ErrProtocol = 2'b11;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  sel_q, sel_d;
  logic           hit_q, hit_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  logic           err_valid_q;
  logic [1:0]     err_code_q;
  logic [31:0]    err_addr_q;
  logic [15:0]    err_cnt_q;

  logic           hit_any;
  logic [IW-1:0]  hit_idx;
  logic           wd_expire;
  logic           bus_err;
  logic [1:0]     bus_code;

  // Scan from the top down so the lowest matching slave index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if (m_paddr[31:DEC_LSB] == BASE[i*PW +: PW]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign wd_expire = (TIMEOUT != 0) && (wcnt_q == WCW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hit_d     = hit_q;
    wcnt_d    = wcnt_q;
    s_psel    = '0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    bus_err   = 1'b0;
    bus_code  = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (m_psel && !m_penable) begin
          if (hit_any) s_psel[hit_idx] = 1'b1;
          sel_d   = hit_idx;
          hit_d   = hit_any;
          wcnt_d  = '0;
          state_d = StAccess;
        end else if (m_psel && m_penable) begin
          // ACCESS without a preceding SETUP: bus answers with an error.
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          bus_err   = 1'b1;
          bus_code  = ErrProtocol;
        end
      end
      StAccess: begin
        if (!m_psel) begin
          // Master abandoned the transfer: quietly release the slave.
          state_d = StIdle;
        end else if (!hit_q) begin
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          bus_err   = 1'b1;
          bus_code  = ErrUnmapped;
          state_d   = StIdle;
        end else if (wd_expire) begin
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          bus_err   = 1'b1;
          bus_code  = ErrTimeout;
          state_d   = StIdle;
        end else begin
          s_psel[sel_q] = 1'b1;
          m_prdata      = s_prdata[sel_q*DW +: DW];
          m_pready      = s_pready[sel_q];
          m_pslverr     = s_pslverr[sel_q];
          if (s_pready[sel_q]) begin
            state_d = StIdle;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are held quiet for as long as reset is asserted.
    if (preset) begin
      s_psel    = '0;
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
      m_prdata  = '0;
      bus_err   = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      hit_q       <= 1'b0;
      wcnt_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hit_q       <= hit_d;
      wcnt_q      <= wcnt_d;
      err_valid_q <= bus_err;
      if (bus_err) begin
        err_code_q <= bus_code;
        err_addr_q <= m_paddr;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign s_penable = m_penable;
  assign s_pwrite  = m_pwrite;
  assign s_paddr   = m_paddr;
  assign s_pwdata  = m_pwdata;

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
